// File: rtl/time_mgr.sv
// time_mgr: FPGA time base driven by PCParser.
// Produces unit/epoch ticks, a running epoch count, a downstream stall when
// the PC time stream runs ahead, and epoch-delayed acks for do_wait tokens.
module time_mgr #(
  parameter int Nunit  = 16,
  parameter int Nepoch = 10,
  parameter int Ntime  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_time,
  input  logic [Nunit-1:0]  unit_len,
  input  logic [Nepoch-1:0] epoch_len,
  input  logic [Ntime-1:0]  PC_epochs_elapsed,
  input  logic              do_wait_v,
  input  logic [Nepoch-1:0] do_wait_d,
  output logic              do_wait_a,
  output logic              unit_tick,
  output logic              epoch_tick,
  output logic [Ntime-1:0]  BD_epochs_elapsed,
  output logic              stall_dn,
  output logic              waiting
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_ACK
  } state_t;

  logic [Nunit-1:0]  r_cyc_cnt;
  logic [Nepoch-1:0] r_unit_cnt;
  logic [Ntime-1:0]  r_bd_epochs;
  state_t            r_state;
  logic [Nepoch-1:0] r_rem;
  logic              r_ack;

  logic [Nunit-1:0]  w_unit_last;
  logic [Nepoch-1:0] w_epoch_last;
  logic              w_unit_tick;
  logic              w_epoch_tick;
  state_t            w_next_state;
  logic [Nepoch-1:0] w_next_rem;

  // Last index of a unit / epoch; a programmed length of 0 behaves as 1.
  assign w_unit_last  = (unit_len  == '0) ? '0 : unit_len  - Nunit'(1);
  assign w_epoch_last = (epoch_len == '0) ? '0 : epoch_len - Nepoch'(1);

  // The >= compares keep the counters bounded if a length shrinks mid-count.
  assign w_unit_tick  = !reset_time && (r_cyc_cnt >= w_unit_last);
  assign w_epoch_tick = w_unit_tick && (r_unit_cnt >= w_epoch_last);

  // Cycle counter and unit counter; reset_time holds both at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc_cnt  <= '0;
      r_unit_cnt <= '0;
    end else if (reset_time) begin
      r_cyc_cnt  <= '0;
      r_unit_cnt <= '0;
    end else begin
      r_cyc_cnt <= w_unit_tick ? '0 : r_cyc_cnt + Nunit'(1);
      if (w_epoch_tick) begin
        r_unit_cnt <= '0;
      end else if (w_unit_tick) begin
        r_unit_cnt <= r_unit_cnt + Nepoch'(1);
      end
    end
  end

  // Completed-epoch count, wrapping naturally at 2^Ntime.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bd_epochs <= '0;
    end else if (reset_time) begin
      r_bd_epochs <= '0;
    end else if (w_epoch_tick) begin
      r_bd_epochs <= r_bd_epochs + Ntime'(1);
    end
  end

  // Wait FSM next-state logic: accept a token in IDLE, count epochs, ack.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (do_wait_v) begin
          if (do_wait_d == '0) begin
            w_next_state = S_ACK;
          end else begin
            w_next_rem   = do_wait_d;
            w_next_state = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (w_epoch_tick) begin
          w_next_rem = r_rem - Nepoch'(1);
          if (r_rem == Nepoch'(1)) begin
            w_next_state = S_ACK;
          end
        end
      end
      S_ACK: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Wait FSM state, remaining-epoch count and the registered ack pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
      r_ack   <= (w_next_state == S_ACK);
    end
  end

  assign do_wait_a         = r_ack;
  assign unit_tick         = w_unit_tick;
  assign epoch_tick        = w_epoch_tick;
  assign BD_epochs_elapsed = r_bd_epochs;
  assign stall_dn          = (PC_epochs_elapsed > r_bd_epochs);
  assign waiting           = (r_state != S_IDLE) || do_wait_v;

endmodule
